// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter, LSB first, one line
// transition per `ce` strobe. Bytes may arrive on consecutive clocks; a byte
// offered while the FIFO is full is dropped and latches `overflow`.
// The data byte input is named byte_in because `byte` is a reserved word.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the stop
// bit (11-period frames).
module uart_tx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic       byte_dv,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] StParity = 3'd4;
`endif

   localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

   logic [2:0]        state_q, state_d;
   logic              tx_q, tx_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif
   logic [7:0]        mem_q [DEPTH];

   logic              full;
   logic              empty;
   logic              wr_en;
   logic              pop;
   logic [7:0]        head;

   assign full  = (count_q == FullCount);
   assign empty = (count_q == '0);
   // Full is judged on the pre-edge count, even if a pop happens on this edge.
   assign wr_en = byte_dv && !full;
   assign head  = mem_q[rd_ptr_q];

   // FSM next state, line driver and pop decision.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (ce) begin
         case (state_q)
            StIdle, StStop: begin
               if (!empty) begin
                  // Back-to-back frames: the stop period ends straight into a start bit.
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = StStart;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
            StStart: begin
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = 3'd0;
               state_d   = StData;
            end
            StData: begin
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = StParity;
`else
                  tx_d    = 1'b1;
                  state_d = StStop;
`endif
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               tx_d    = 1'b1;
               state_d = StStop;
            end
`endif
            default: begin
               tx_d    = 1'b1;
               state_d = StIdle;
            end
         endcase
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (byte_dv & full);
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         tx_q       <= 1'b1;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem_q[wr_ptr_q] <= byte_in;
   end

   assign tx        = tx_q;
   assign busy      = (state_q != StIdle) || !empty;
   assign fifo_full = full;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic,
// compared every clock against a queue-based model of the FIFO and the line.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic       byte_dv = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       tx, busy, fifo_full, overflow;

   int checks = 0;
   int errors = 0;

   // Reference model: queued bytes, pending line bits of the current frame.
   logic [7:0] fifo_m [$];
   logic       line_m [$];
   logic       in_frame = 1'b0;
   logic       exp_tx = 1'b1;
   logic       exp_ovf = 1'b0;

   uart_tx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .byte_dv   (byte_dv),
      .byte_in   (byte_in),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model over the edge, compare outputs.
   task automatic step(input logic c, input logic dv, input logic [7:0] b, input logic r);
      int pre;
      logic [7:0] d;
      rst = r; ce = c; byte_dv = dv; byte_in = b;
      @(posedge clk);
      if (r) begin
         fifo_m.delete();
         line_m.delete();
         in_frame = 1'b0;
         exp_tx   = 1'b1;
         exp_ovf  = 1'b0;
      end else begin
         pre = fifo_m.size();
         if (c) begin
            if (line_m.size() != 0) begin
               exp_tx = line_m.pop_front();
            end else if (pre != 0) begin
               d        = fifo_m.pop_front();
               in_frame = 1'b1;
               exp_tx   = 1'b0;
               for (int i = 0; i < 8; i++) line_m.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
               line_m.push_back(^d);
`endif
               line_m.push_back(1'b1);
            end else begin
               in_frame = 1'b0;
               exp_tx   = 1'b1;
            end
         end
         if (dv) begin
            if (pre < DEPTH) fifo_m.push_back(b);
            else exp_ovf = 1'b1;
         end
      end
      #1;
      check_eq("tx", 32'(tx), 32'(exp_tx));
      check_eq("busy", 32'(busy), 32'(in_frame || fifo_m.size() != 0));
      check_eq("fifo_full", 32'(fifo_full), 32'(fifo_m.size() == DEPTH));
      check_eq("overflow", 32'(overflow), 32'(exp_ovf));
   endtask

   task automatic run_ce(input int n, input int period);
      for (int i = 0; i < n; i++) step((i % period) == period - 1, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic c, dv;
      // Reset and single 0xA5 frame with ce every 4 clocks.
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      run_ce(60, 4);

      // Two consecutive writes -> back-to-back frames.
      step(1'b0, 1'b1, 8'h34, 1'b0);
      step(1'b0, 1'b1, 8'h12, 1'b0);
      run_ce(100, 4);

      // Fill past full with ce held low, then drain all 16.
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      run_ce(400, 2);

      // Full FIFO with a write landing on a STOP-state pop edge.
      step(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i + 8'h40), 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'hEE, 1'b0);
      for (int i = 0; i < 600; i++) begin
         c  = (i % 3) == 2;
         dv = c && in_frame && line_m.size() == 0 && fifo_m.size() == DEPTH;
         step(c, dv, 8'hC3, 1'b0);
      end

      // Reset in the middle of a frame with bytes queued.
      step(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h5A + i), 1'b0);
      run_ce(16, 2);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      run_ce(60, 2);

      // Random traffic.
      for (int i = 0; i < 4000; i++)
         step($urandom_range(2) == 0, $urandom_range(3) == 0, 8'($urandom),
              $urandom_range(599) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Serial transmit stage directly downstream of the word-to-byte splitter. Accepts byte strobes, which may arrive on consecutive clocks with no backpressure, into a small FIFO. Drains the FIFO as 8N1 UART frames, LSB first, timed by a one-clock bit-period strobe `ce`. Drives the physical TX line.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width. The count register is ADDR_W+1 bits wide.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; synchronous, active-high.
ce  input  1  bit-period strobe, one clk wide. All line transitions occur only on clk edges where ce=1.
byte_dv  input  1  write strobe for byte. Valid on any cycle, including consecutive cycles.
byte  input  8  data byte. Sampled when byte_dv=1.
tx  output  1  serial line. Registered output, idle high.
busy  output  1  high when state!=IDLE or FIFO count!=0.
fifo_full  output  1  count==DEPTH.
overflow  output  1  sticky; set when a byte is dropped, cleared only by rst.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - tx=1, busy=0, fifo_full=0, overflow=0.
  - Pointers and count are cleared; state=IDLE; shift register and bit_cnt are zeroed.
  - A reset mid-frame aborts the frame: tx is 1 on the clk after the reset edge, and FIFO contents are discarded.
- FIFO write:
  - If byte_dv=1 and count<DEPTH, byte is stored at wr_ptr; wr_ptr wraps modulo DEPTH.
  - If byte_dv=1 and count==DEPTH at the edge, the byte is dropped and overflow<=1. This holds even if a pop occurs on the same edge: full is judged on the pre-edge count.
- FIFO pop: happens only inside the FSM as described below. On a simultaneous write and pop, count is unchanged.
- FSM, states IDLE, START, DATA, STOP (plus PARITY, see Optional Feature). All transitions occur only on edges with ce=1; with ce=0 the state and tx hold.
  - IDLE: tx=1.
    - On ce with count!=0: pop the head into shift_reg, tx<=0, go to START.
    - On ce with count==0: stay in IDLE.
  - START: on ce, tx<=shift_reg[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on ce:
    - If bit_cnt==7: tx<=1, go to STOP.
    - Else: tx<=shift_reg[0], shift, bit_cnt<=bit_cnt+1.
  - STOP: tx is held at 1 for one ce period. On ce:
    - If count!=0: pop, tx<=0, go to START. Frames run back-to-back with no idle gap.
    - Else: go to IDLE with tx=1.
- Frame length: 10 ce periods (start, 8 data, stop).
- Latency: a byte written into an empty, idle FIFO produces the falling start edge at the first ce edge strictly after the write edge.
- A byte_dv on the same edge as an IDLE pop check is not visible to that check; it is handled on the next ce.
- busy deasserts on the clk where STOP→IDLE occurs with the FIFO empty.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP.
  - On the DATA bit_cnt==7 ce, tx<=even parity (XOR of the 8 data bits), go to PARITY.
  - On the next ce, tx<=1, go to STOP.
  - Frame length is 11 ce periods. Parity is computed when the byte is popped and held in a register.
- Not defined: no PARITY state, no parity register; 10-period 8N1 frames exactly as in Behaviour.

Test Plan:
- Reset, then ce every 4 clks, write 0xA5 once → tx per ce period is 0,1,0,1,0,0,1,0,1,1, then stays 1. busy goes 1 then 0 after the stop bit; overflow=0.
- byte_dv on two consecutive clks with 0x34 then 0x12 → back-to-back frames 0,0,0,1,0,1,1,0,0,1 then 0,0,1,0,0,1,0,0,0,1. No idle period between them; exactly 20 ce periods of busy.
- Hold ce=0, write DEPTH+2 bytes (0x00..0x11) → fifo_full=1 after the 16th write and overflow=1 after the 17th. Enabling ce then yields exactly 16 frames, 0x00..0x0F in order.
- Assert rst for one clk during DATA of a frame with 3 bytes queued → tx=1, busy=0, fifo_full=0 on the next clk. No further frames are sent after ce resumes.
- With the FIFO full and the FSM in STOP popping, byte_dv coincides with the pop edge → that byte is dropped, overflow=1, and count ends at DEPTH-1.
- UART_TX_PARITY_EN defined, write 0xA5 then 0x07 → frames 0,1,0,1,0,0,1,0,1,0,1 and 0,1,1,1,0,0,0,0,0,1,1, each 11 ce periods.
